layer_mac_scheduler: RTL and testbench
======================================

LAYER_MAC_SCHEDULER -- requirements
Module: layer_mac_scheduler

Interface
REQ-001 The block SHALL have parameter N_IN, default 10, meaning inputs per neuron (2..64).
REQ-002 The block SHALL have parameter N_OUT, default 16, meaning neurons per layer (1..64).
REQ-003 The block SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: layer-evaluation request, sampled only in IDLE.
REQ-006 The block SHALL have port busy, output, 1 bit: high in every non-IDLE state.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse after the last neuron's output.
REQ-008 The block SHALL have port in_addr, output, 6 bits: activation memory read address.
REQ-009 The block SHALL have port in_data, input, 16 bits: signed activation, valid one cycle after in_addr.
REQ-010 The block SHALL have port w_addr, output, 12 bits: weight address, equal to neuron*N_IN + k.
REQ-011 The block SHALL have port w_data, input, 16 bits: signed weight, valid one cycle after w_addr.
REQ-012 The block SHALL have port b_addr, output, 6 bits: bias address, equal to the current neuron index.
REQ-013 The block SHALL have port b_data, input, 16 bits: signed bias, valid one cycle after b_addr.
REQ-014 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse marking a neuron result.
REQ-015 The block SHALL have port out_idx, output, 6 bits: neuron index of the current result.
REQ-016 The block SHALL have port out_data, output, 16 bits: ReLU result, valid while out_valid is high.

Function
REQ-017 FSM states SHALL be IDLE, MAC, DRAIN, OUT and DONE.
REQ-018 IDLE with start=1 SHALL go to MAC, clearing neuron=0, k=0 and acc=0.
REQ-019 MAC SHALL drive in_addr=k and w_addr=neuron*N_IN+k, incrementing k each cycle for N_IN cycles (k=0..N_IN-1).
REQ-020 Each cycle after a MAC-cycle address (that MAC cycle's k>0, or DRAIN) SHALL do acc <= acc + lower16(in_data*w_data), both operands signed.
REQ-021 After k=N_IN-1, MAC SHALL go to DRAIN, which accumulates the last product, then to OUT.
REQ-022 b_addr SHALL hold neuron through MAC, DRAIN and OUT, so b_data is stable by OUT.
REQ-023 OUT SHALL pulse out_valid with out_idx=neuron and out_data = s[15]==0 ? s : 0, where s = lower16(acc + b_data).
REQ-024 In OUT: if neuron<N_OUT-1, go to MAC with neuron+1, k=0, acc=0; else go to DONE.
REQ-025 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-026 Each neuron SHALL take exactly N_IN+2 cycles.
REQ-027 done SHALL assert exactly N_OUT*(N_IN+2)+1 cycles after the start-sampling edge (192+1 = 193 at defaults).
REQ-028 All arithmetic SHALL be 16-bit two's-complement, wrapping silently with no saturation or overflow flag.
REQ-029 start while busy (including in the DONE cycle) SHALL be ignored and not queued.
REQ-030 out_data and out_idx SHALL hold their last values when out_valid is low.
REQ-031 Address outputs SHALL hold their last values outside MAC, DRAIN and OUT.

Reset
REQ-032 While reset is high, the state SHALL be IDLE and busy, done and out_valid SHALL be 0.
REQ-033 While reset is high, in_addr, w_addr, b_addr, out_idx, out_data, acc, k and neuron SHALL be 0.
REQ-034 Reset SHALL take priority over start and over every state, including mid-MAC.
REQ-035 After reset, no out_valid or done SHALL occur from an aborted layer.
REQ-036 The first start accepted after reset release SHALL run a complete fresh layer.

Verification
REQ-037 Defaults; all in_data=1, w_data=1, b_data=-1; start -> 16 out_valid pulses, out_idx 0..15, each out_data=9; done at cycle 193.
REQ-038 All w_data=-1, in_data=3, b_data=0 -> every out_data=0 (ReLU clamp of -30).
REQ-039 in_data=256, w_data=256 (product wraps to 0), b_data=5 -> every out_data=5.
REQ-040 Mixed sum reaching 0x8000 (e.g. 10 products of 3277 giving 32770) -> out_data=0, confirming sign-bit wrap.
REQ-041 Assert reset during neuron 7 MAC -> next cycle busy=0 and all outputs 0; no done follows; a later start gives a full 16-result run.
REQ-042 Pulse start at cycles 5, 50 and the DONE cycle of one run -> exactly one run (16 results, one done); address sequence checked against neuron*10+k.

Source files
------------

// File: rtl/layer_mac_scheduler_if.sv
// Memory-read and result bus between the layer MAC scheduler and its memories/consumer.
// All address and data widths are fixed by the activation/weight/bias memory map.
interface layer_mac_scheduler_if;
  logic [5:0]  in_addr;
  logic [15:0] in_data;
  logic [11:0] w_addr;
  logic [15:0] w_data;
  logic [5:0]  b_addr;
  logic [15:0] b_data;
  logic        out_valid;
  logic [5:0]  out_idx;
  logic [15:0] out_data;

  modport master (
    output in_addr, w_addr, b_addr, out_valid, out_idx, out_data,
    input  in_data, w_data, b_data
  );
  modport slave (
    input  in_addr, w_addr, b_addr, out_valid, out_idx, out_data,
    output in_data, w_data, b_data
  );
endinterface

// File: rtl/layer_mac_scheduler.sv
// Sequences one dense layer: per neuron, N_IN multiply-accumulates against
// 1-cycle-latency memories, bias add, ReLU, one result pulse; then a done pulse.
module layer_mac_scheduler #(
  parameter int N_IN  = 10,
  parameter int N_OUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  layer_mac_scheduler_if.master bus
);
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, OUT, DONE} state_t;

  localparam logic [5:0] K_LAST = 6'(N_IN - 1);
  localparam logic [5:0] N_LAST = 6'(N_OUT - 1);

  state_t state, state_nxt;
  logic [5:0]  k, neuron;
  logic [15:0] acc, prod, acc_sum, s;
  logic [5:0]  in_addr_q, b_addr_q, out_idx_q;
  logic [11:0] w_addr_q;
  logic [15:0] out_data_q;

  // Low half of a two's-complement product does not depend on signedness.
  assign prod    = 16'($signed(bus.in_data) * $signed(bus.w_data));
  assign acc_sum = acc + prod;
  assign s       = acc_sum + bus.b_data;

  assign bus.in_addr  = in_addr_q;
  assign bus.w_addr   = w_addr_q;
  assign bus.b_addr   = b_addr_q;
  assign bus.out_idx  = out_idx_q;
  assign bus.out_data = out_data_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    done          = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = MAC;
      MAC:   if (k == K_LAST) state_nxt = DRAIN;
      DRAIN: state_nxt = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        state_nxt     = (neuron == N_LAST) ? DONE : MAC;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k          <= '0;
      neuron     <= '0;
      acc        <= '0;
      in_addr_q  <= '0;
      w_addr_q   <= '0;
      b_addr_q   <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          k         <= '0;
          neuron    <= '0;
          acc       <= '0;
          in_addr_q <= '0;
          w_addr_q  <= '0;
          b_addr_q  <= '0;
        end
        MAC: begin
          // Data on the bus belongs to the previous cycle's address.
          if (k != '0) acc <= acc_sum;
          if (k != K_LAST) begin
            k         <= k + 6'd1;
            in_addr_q <= k + 6'd1;
            w_addr_q  <= w_addr_q + 12'd1;
          end
        end
        DRAIN: begin
          // Result registered here so it appears together with out_valid in OUT.
          acc        <= acc_sum;
          out_idx_q  <= neuron;
          out_data_q <= s[15] ? 16'd0 : s;
        end
        OUT: if (neuron != N_LAST) begin
          neuron    <= neuron + 6'd1;
          k         <= '0;
          acc       <= '0;
          in_addr_q <= '0;
          w_addr_q  <= w_addr_q + 12'd1;
          b_addr_q  <= neuron + 6'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_mac_scheduler.sv
// Directed bench for layer_mac_scheduler: uniform-memory vector table plus
// address-pattern, ignored-start and mid-layer reset sequences.
module tb_layer_mac_scheduler;
  logic clk = 1'b0;
  logic reset, start;
  logic busy, done;

  layer_mac_scheduler_if bus();

  layer_mac_scheduler #(.N_IN(10), .N_OUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] in_mem [64];
  logic [15:0] w_mem  [4096];
  logic [15:0] b_mem  [64];

  always @(posedge clk) begin
    bus.in_data <= in_mem[bus.in_addr];
    bus.w_data  <= w_mem[bus.w_addr];
    bus.b_data  <= b_mem[bus.b_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic fill(input logic [15:0] iv, input logic [15:0] wv, input logic [15:0] bv);
    for (int i = 0; i < 64; i++) begin in_mem[i] = iv; b_mem[i] = bv; end
    for (int i = 0; i < 4096; i++) w_mem[i] = wv;
  endtask

  // Runs one layer from IDLE; formula=1 expects 550*n+330 (address-pattern memories).
  task automatic run_layer(input string name, input bit formula, input logic [15:0] exp_c,
                           input bit extra_starts);
    int cyc, n_out, n_done, done_cyc, n, p;
    bit addr_ok, busy_ok, idle_ok;
    logic [15:0] e;
    n_out = 0; n_done = 0; done_cyc = 0;
    addr_ok = 1; busy_ok = 1; idle_ok = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 1;
    while (n_done == 0 && cyc <= 400) begin
      if (extra_starts) start = (cyc == 5 || cyc == 50 || cyc == 193);
      n = (cyc - 1) / 12;
      p = (cyc - 1) % 12;
      if (p < 10 && n < 16)
        if (bus.in_addr !== 6'(p) || bus.w_addr !== 12'(n * 10 + p) || bus.b_addr !== 6'(n))
          addr_ok = 0;
      if (busy !== 1'b1) busy_ok = 0;
      if (bus.out_valid === 1'b1) begin
        e = formula ? 16'(550 * n_out + 330) : exp_c;
        chk({name, " out_idx"}, bus.out_idx, n_out);
        chk({name, " out_data"}, bus.out_data, e);
        chk({name, " out_slot"}, cyc, 12 * (n_out + 1));
        n_out++;
      end
      if (done === 1'b1) begin n_done = 1; done_cyc = cyc; end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({name, " result_count"}, n_out, 16);
    chk({name, " done_cycle"}, done_cyc, 193);
    chk({name, " addr_seq"}, addr_ok, 1);
    chk({name, " busy_during_run"}, busy_ok, 1);
    chk({name, " done_one_cycle"}, done, 0);
    chk({name, " idle_after"}, busy, 0);
    chk({name, " out_data_hold"}, bus.out_data, formula ? 16'(550 * 15 + 330) : exp_c);
    if (extra_starts) begin
      repeat (20) begin
        @(negedge clk);
        if (busy !== 1'b0 || bus.out_valid !== 1'b0 || done !== 1'b0) idle_ok = 0;
      end
      chk({name, " no_queued_run"}, idle_ok, 1);
    end
  endtask

  typedef struct {
    logic [15:0] in_v;
    logic [15:0] w_v;
    logic [15:0] b_v;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [7];

  initial begin
    bit quiet_ok;
    vecs[0] = '{16'd1,    16'd1,      16'hFFFF, 16'd9,     "ones"};
    vecs[1] = '{16'd3,    16'hFFFF,   16'd0,    16'd0,     "relu_clamp"};
    vecs[2] = '{16'd256,  16'd256,    16'd5,    16'd5,     "prod_wrap"};
    vecs[3] = '{16'd3277, 16'd1,      16'd0,    16'd0,     "sign_wrap"};
    vecs[4] = '{16'd3276, 16'd1,      16'd7,    16'd32767, "max_pos"};
    vecs[5] = '{16'hFFFE, 16'hFFFD,   16'hFFC4, 16'd0,     "neg_neg_zero"};
    vecs[6] = '{16'd100,  16'd7,      16'hFC18, 16'd6000,  "mid_bias"};

    fill(16'd0, 16'd0, 16'd0);
    reset = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset out_valid", bus.out_valid, 0);
    chk("reset in_addr", bus.in_addr, 0);
    chk("reset w_addr", bus.w_addr, 0);
    chk("reset out_data", bus.out_data, 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].in_v, vecs[i].w_v, vecs[i].b_v);
      run_layer(vecs[i].name, 1'b0, vecs[i].exp, 1'b0);
      repeat (2) @(negedge clk);
    end

    // Distinct per-address contents expose any addressing error.
    for (int i = 0; i < 64; i++) begin in_mem[i] = 16'(i + 1); b_mem[i] = 16'd0; end
    for (int i = 0; i < 4096; i++) w_mem[i] = 16'(i);
    run_layer("addr_pattern", 1'b1, 16'd0, 1'b0);
    repeat (2) @(negedge clk);

    fill(16'd1, 16'd1, 16'hFFFF);
    run_layer("ignored_starts", 1'b0, 16'd9, 1'b1);

    // Abort during neuron 7 MAC (cycle 88, k=3).
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (87) @(negedge clk);
    chk("pre_reset out_idx", bus.out_idx, 6);
    chk("pre_reset busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort out_valid", bus.out_valid, 0);
    chk("abort in_addr", bus.in_addr, 0);
    chk("abort w_addr", bus.w_addr, 0);
    chk("abort b_addr", bus.b_addr, 0);
    chk("abort out_idx", bus.out_idx, 0);
    chk("abort out_data", bus.out_data, 0);
    reset = 1'b0;
    quiet_ok = 1;
    repeat (250) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || bus.out_valid !== 1'b0) quiet_ok = 0;
    end
    chk("abort no_residual_activity", quiet_ok, 1);
    run_layer("after_abort", 1'b0, 16'd9, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
